mod_n_counter: RTL and testbench
================================

MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and modulus width in bits.
REQ-002 Parameter MOD_DEFAULT, default 6, modulus after reset; legal range 2..2^WIDTH-1.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable; counter holds when low.
REQ-006 up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 mod_wr  input  1  request to change modulus to mod_val.
REQ-010 mod_val  input  WIDTH  requested modulus.
REQ-011 q  output  WIDTH  current count, always < active modulus.
REQ-012 tc  output  1  terminal count, combinational.
REQ-013 wrap  output  1  registered one-cycle pulse after a wrap.
REQ-014 err  output  1  registered one-cycle pulse on a rejected load or modulus write.

Function
REQ-015 The block SHALL hold active_mod (M), pending_mod and pending_valid registers.
REQ-016 Per-edge priority SHALL be: rst, then load, then en counting, then hold.
REQ-017 With en=1, up=1 and no load, q SHALL go to q+1, or to 0 when q==M-1 (wrap).
REQ-018 With en=1, up=0 and no load, q SHALL go to q-1, or to M'-1 when q==0 (wrap); M' is the modulus in force after that edge.
REQ-019 tc SHALL equal en & ((up & q==M-1) | (~up & q==0)).
REQ-020 wrap SHALL be 1 for exactly the cycle after each wrap edge and 0 otherwise.
REQ-021 When mod_wr=1 and mod_val>=2, pending_mod SHALL capture mod_val and pending_valid SHALL be set; a later write overwrites an earlier one.
REQ-022 When mod_wr=1 and mod_val<2, the write SHALL be ignored and err SHALL pulse the next cycle.
REQ-023 A pending modulus SHALL take effect only on a wrap edge or a load edge, and pending_valid SHALL then clear.
REQ-024 When mod_wr and a wrap or load occur on the same edge, the new mod_val SHALL become pending and SHALL NOT take effect on that edge; any older pending value is applied.
REQ-025 On load, q SHALL take load_val if load_val < M'; otherwise q SHALL become 0 and err SHALL pulse.
REQ-026 Load SHALL NOT assert wrap, even when en=1.
REQ-027 Count latency SHALL be one edge; q SHALL never hold a value >= M.

Reset
REQ-028 Asserting rst SHALL immediately set q=0, wrap=0, err=0, M=MOD_DEFAULT, pending_valid=0.
REQ-029 Reset asserted mid-count or while a modulus write is pending SHALL discard all pending state.
REQ-030 The first count SHALL occur on the first rising edge after rst deasserts with en=1.

Structure
REQ-031 Package counter_pkg SHALL hold the MIN_MOD=2 constant and the direction encodings DIR_UP=1 and DIR_DN=0.
REQ-032 The pending_mod/pending_valid logic SHALL be a single sub-module, mod_shadow_reg.
REQ-033 All other logic SHALL be in mod_n_counter; no other sub-modules.

Verification (WIDTH=4, MOD_DEFAULT=6)
REQ-034 en=1, up=1 for 8 edges from reset -> q = 1,2,3,4,5,0,1,2; tc high at q=5; wrap high the cycle q=0.
REQ-035 up=0 from q=0 -> q = 5,4,3,2,1,0,5; wrap after each 0->5 transition; tc high at q=0.
REQ-036 mod_wr with mod_val=10 at q=2 while counting up -> q continues to 5, wraps to 0; then counts 0..9; wrap after 9->0.
REQ-037 load=1 with load_val=7 while M=6 -> q=0 and one err pulse; load_val=3 -> q=3 and no err; mod_wr with mod_val=1 -> err pulse and M unchanged.
REQ-038 rst asserted asynchronously mid-cycle at q=4 with a write pending -> q=0 before the next edge, and M=6 after release.
REQ-039 Same-edge load=1, load_val=2 and mod_wr with mod_val=3 while counting -> q=2, wrap=0, M unchanged until the next wrap or load.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the modulo-N counter
package counter_pkg;

    // Smallest modulus the counter accepts; anything below it is rejected.
    localparam int MIN_MOD = 2;

    // Direction encodings for the up input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/mod_n_counter_if.sv
// rtl/mod_n_counter_if.sv - control/status bundle of the modulo-N counter
interface mod_n_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mod_wr;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             err;

    modport master (
        output en, up, load, load_val, mod_wr, mod_val,
        input  q, tc, wrap, err
    );

    modport slave (
        input  en, up, load, load_val, mod_wr, mod_val,
        output q, tc, wrap, err
    );

endinterface

// File: rtl/mod_shadow_reg.sv
// rtl/mod_shadow_reg.sv - holds a requested modulus until the counter can apply it
module mod_shadow_reg
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic             apply_i,
    output logic [WIDTH-1:0] pending_mod_o,
    output logic             pending_valid_o,
    output logic             reject_o
);

    localparam logic [WIDTH-1:0] MIN_MOD_W = WIDTH'(MIN_MOD);

    logic [WIDTH-1:0] pending_mod_q, pending_mod_d;
    logic             pending_valid_q, pending_valid_d;
    logic             accept;

    assign accept   = wr_i & (val_i >= MIN_MOD_W);
    assign reject_o = wr_i & (val_i <  MIN_MOD_W);

    // Consuming the old value and capturing a new one can share an edge;
    // the new write survives because it is ordered after the clear.
    always_comb begin
        pending_mod_d   = pending_mod_q;
        pending_valid_d = pending_valid_q;
        if (apply_i) begin
            pending_valid_d = 1'b0;
        end
        if (accept) begin
            pending_mod_d   = val_i;
            pending_valid_d = 1'b1;
        end
    end

    // Shadow state register, cleared by reset so no stale request survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_mod_q   <= '0;
            pending_valid_q <= 1'b0;
        end else begin
            pending_mod_q   <= pending_mod_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    assign pending_mod_o   = pending_mod_q;
    assign pending_valid_o = pending_valid_q;

endmodule

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - up/down modulo-N counter with deferred modulus update
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MOD_DEFAULT = 6
) (
    input  logic            clk,
    input  logic            rst,
    mod_n_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MOD_RST = WIDTH'(MOD_DEFAULT);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] pending_mod;
    logic             pending_valid;
    logic             reject;
    logic             at_top;
    logic             at_zero;
    logic             tc;
    logic             wrap_ev;
    logic             apply;
    logic [WIDTH-1:0] mod_after;

    assign at_top  = (q_q == mod_q - 1'b1);
    assign at_zero = (q_q == '0);
    assign tc      = bus.en & (((bus.up == DIR_UP) & at_top) | ((bus.up == DIR_DN) & at_zero));

    // A load takes priority over counting, so it suppresses the wrap event.
    assign wrap_ev = tc & ~bus.load;
    assign apply   = wrap_ev | bus.load;

    // Modulus that is in force after this edge; the write arriving on this
    // same edge only lands in the shadow and is not visible here.
    assign mod_after = (apply & pending_valid) ? pending_mod : mod_q;

    mod_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
        .clk             (clk),
        .rst             (rst),
        .wr_i            (bus.mod_wr),
        .val_i           (bus.mod_val),
        .apply_i         (apply),
        .pending_mod_o   (pending_mod),
        .pending_valid_o (pending_valid),
        .reject_o        (reject)
    );

    // Next-state: load beats counting; down-wrap lands on the new modulus.
    always_comb begin
        q_d    = q_q;
        mod_d  = mod_after;
        wrap_d = wrap_ev;
        err_d  = reject;
        if (bus.load) begin
            if (bus.load_val < mod_after) begin
                q_d = bus.load_val;
            end else begin
                q_d   = '0;
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up == DIR_UP) begin
                q_d = at_top ? '0 : q_q + 1'b1;
            end else begin
                q_d = at_zero ? mod_after - 1'b1 : q_q - 1'b1;
            end
        end
    end

    // Counter, modulus and pulse registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            mod_q  <= MOD_RST;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            mod_q  <= mod_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - self-checking bench for mod_n_counter
module tb_mod_n_counter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mod_n_counter_if #(.WIDTH(4)) bus ();

    mod_n_counter #(.WIDTH(4), .MOD_DEFAULT(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] lv;
        logic       mw;
        logic [3:0] mv;
        logic [3:0] eq;
        logic       etc;
        logic       ewrap;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];

    // Reference state: count, modulus, pending request and expected pulses.
    int mq, mm, pm;
    bit pv, mwrap, merr;

    function automatic vec_t mk(logic en, logic up, logic ld, logic [3:0] lv, logic mw,
                                logic [3:0] mv, logic [3:0] eq, logic etc, logic ew, logic ee);
        vec_t v;
        v.en = en; v.up = up; v.ld = ld; v.lv = lv; v.mw = mw; v.mv = mv;
        v.eq = eq; v.etc = etc; v.ewrap = ew; v.eerr = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq = 0; mm = 6; pm = 0; pv = 0; mwrap = 0; merr = 0;
    endtask

    task automatic model_edge(input bit en, input bit up, input bit ld, input int lv,
                              input bit mw, input int mv);
        bit wev, app;
        int nm;
        merr = 0;
        wev  = en && !ld && (up ? (mq == mm - 1) : (mq == 0));
        app  = wev || ld;
        nm   = (app && pv) ? pm : mm;
        if (app) pv = 0;
        if (ld) begin
            if (lv < nm) mq = lv;
            else begin mq = 0; merr = 1; end
        end else if (en) begin
            if (up) mq = (mq + 1) % mm;
            else    mq = (mq == 0) ? nm - 1 : mq - 1;
        end
        mm    = nm;
        mwrap = wev;
        if (mw) begin
            if (mv >= 2) begin pm = mv; pv = 1; end
            else merr = 1;
        end
    endtask

    function automatic bit model_tc(bit en, bit up);
        return en && (up ? (mq == mm - 1) : (mq == 0));
    endfunction

    // Apply one set of inputs across one rising edge; return #1 after it.
    task automatic step(input logic en, input logic up, input logic ld, input logic [3:0] lv,
                        input logic mw, input logic [3:0] mv);
        bus.en = en; bus.up = up; bus.load = ld; bus.load_val = lv;
        bus.mod_wr = mw; bus.mod_val = mv;
        @(posedge clk);
        model_edge(en, up, ld, int'(lv), mw, int'(mv));
        #1;
    endtask

    task automatic do_reset();
        bus.en = 0; bus.up = 0; bus.load = 0; bus.load_val = 0; bus.mod_wr = 0; bus.mod_val = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_q"},    32'(bus.q),    32'(mq));
        check({tag, "_wrap"}, 32'(bus.wrap), 32'(mwrap));
        check({tag, "_err"},  32'(bus.err),  32'(merr));
        check({tag, "_tc"},   32'(bus.tc),   32'(model_tc(bus.en, bus.up)));
    endtask

    initial begin
        int exp036[13];
        n_checks = 0;
        n_fail   = 0;
        bus.en = 0; bus.up = 0; bus.load = 0; bus.load_val = 0; bus.mod_wr = 0; bus.mod_val = 0;
        rst = 1'b1;
        model_reset();
        #2;
        check("reset_q",    32'(bus.q),    0);
        check("reset_wrap", 32'(bus.wrap), 0);
        check("reset_err",  32'(bus.err),  0);
        @(negedge clk);
        rst = 1'b0;

        // Up count from reset, down count, load/modulus rejects, same-edge load+write.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] e;
            e = 4'((i + 1) % 6);
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, e, e == 5, e == 0, 0));
        end
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lv, tbl[i].mw, tbl[i].mv);
            check($sformatf("vec%0d_q", i),    32'(bus.q),    32'(tbl[i].eq));
            check($sformatf("vec%0d_tc", i),   32'(bus.tc),   32'(tbl[i].etc));
            check($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(tbl[i].ewrap));
            check($sformatf("vec%0d_err", i),  32'(bus.err),  32'(tbl[i].eerr));
        end

        // Modulus write at q=2 waits for the 5->0 wrap, then counts to 9.
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 10);
        check("m10_q", 32'(bus.q), 3);
        check("m10_err", 32'(bus.err), 0);
        exp036 = '{4, 5, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        for (int i = 0; i < 13; i++) begin
            step(1, 1, 0, 0, 0, 0);
            check($sformatf("m10_seq%0d_q", i),    32'(bus.q),    32'(exp036[i]));
            check($sformatf("m10_seq%0d_wrap", i), 32'(bus.wrap), 32'(exp036[i] == 0));
        end

        // Asynchronous reset mid-cycle with a pending write and an err pulse live.
        do_reset();
        step(1, 1, 0, 0, 1, 9);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1);
        check("arst_pre_q", 32'(bus.q), 4);
        check("arst_pre_err", 32'(bus.err), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(bus.q), 0);
        check("arst_err", 32'(bus.err), 0);
        check("arst_wrap", 32'(bus.wrap), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 0, 0, 0, 0);
            if (i == 6 || i == 12) begin
                check($sformatf("arst_after%0d_q", i), 32'(bus.q), 0);
                check($sformatf("arst_after%0d_wrap", i), 32'(bus.wrap), 1);
            end
        end

        // Random traffic against the reference model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 131 == 70) do_reset();
            step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 6) == 0, 4'($urandom_range(0, 15)));
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
